// File: rtl/galois_lfsr_checker_if.sv
// Bus bundle for galois_lfsr_checker: received-word input plus lock/error status.
// The master side drives words in; the slave side (the checker) reports status.
interface galois_lfsr_checker_if;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned STATE_W = 2;

    logic                in_valid;
    logic [DATA_W-1:0]   in_data;
    logic                locked;
    logic                err;
    logic                sync_lost;
    logic [DATA_W-1:0]   err_count;
    logic [STATE_W-1:0]  state;

    // Word source / status observer
    modport master (
        output in_valid,
        output in_data,
        input  locked,
        input  err,
        input  sync_lost,
        input  err_count,
        input  state
    );

    // Checker side
    modport slave (
        input  in_valid,
        input  in_data,
        output locked,
        output err,
        output sync_lost,
        output err_count,
        output state
    );

endinterface

// File: rtl/galois_lfsr_checker.sv
// Galois LFSR sequence checker: hunts on a nonzero seed word, verifies
// LOCK_CNT consecutive predicted words before declaring lock, then flywheels
// the prediction and drops lock after LOSS_CNT consecutive mismatches.
// Optional feature macro: LFSR_CHK_ERR_COUNT_EN enables the saturating
// err_count register; without it err_count reads as zero and no counter
// flops exist.
module galois_lfsr_checker #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    galois_lfsr_checker_if.slave  bus
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Next word of the sequence from the current word.
    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] q);
        logic [DATA_W-1:0] n;
        n[15]   = q[1];
        n[14]   = q[15] ^ q[1];
        n[13:5] = q[14:6];
        n[4]    = q[5] ^ q[1];
        n[3]    = q[4];
        n[2]    = q[3] ^ q[1];
        n[1]    = q[2];
        n[0]    = q[1];
        return n;
    endfunction

    state_t              state_q,    state_d;
    logic [DATA_W-1:0]   expected_q, expected_d;
    logic [CNT_W-1:0]    match_q,    match_d;
    logic [CNT_W-1:0]    miss_q,     miss_d;
    logic                locked_q,   locked_d;
    logic                err_q,      err_d;
    logic                sync_lost_q, sync_lost_d;

    logic                word_match_c;
    logic [CNT_W-1:0]    match_inc_c;
    logic [CNT_W-1:0]    miss_inc_c;

    assign word_match_c = (bus.in_data == expected_q);
    assign match_inc_c  = match_q + CNT_W'(1);
    assign miss_inc_c   = miss_q + CNT_W'(1);

    // State, prediction, counters and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            expected_q  <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            sync_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_q     <= match_d;
            miss_q      <= miss_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            sync_lost_q <= sync_lost_d;
        end
    end

    // Next-state and next-output decode; idle cycles hold everything but pulses.
    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        match_d     = match_q;
        miss_d      = miss_q;
        err_d       = 1'b0;
        sync_lost_d = 1'b0;

        if (bus.in_valid) begin
            unique case (state_q)
                HUNT: begin
                    // An all-zero word would seed a dead sequence, so it is skipped.
                    if (bus.in_data != '0) begin
                        expected_d = lfsr_next(bus.in_data);
                        match_d    = '0;
                        state_d    = VERIFY;
                    end
                end
                VERIFY: begin
                    if (word_match_c) begin
                        expected_d = lfsr_next(expected_q);
                        match_d    = match_inc_c;
                        if (match_inc_c == CNT_W'(LOCK_CNT)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        // A bad seed is not a line error; just re-hunt quietly.
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    // Flywheel: keep predicting whether or not this word matched.
                    expected_d = lfsr_next(expected_q);
                    if (word_match_c) begin
                        miss_d = '0;
                    end else begin
                        err_d = 1'b1;
                        if (miss_inc_c == CNT_W'(LOSS_CNT)) begin
                            state_d     = HUNT;
                            sync_lost_d = 1'b1;
                            miss_d      = '0;
                        end else begin
                            miss_d = miss_inc_c;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

`ifdef LFSR_CHK_ERR_COUNT_EN
    logic [DATA_W-1:0] err_count_q;

    // Saturating count of locked-state mismatches; survives loss of lock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q <= '0;
        end else if (err_d && (err_count_q != {DATA_W{1'b1}})) begin
            err_count_q <= err_count_q + DATA_W'(1);
        end
    end

    assign bus.err_count = err_count_q;
`else
    assign bus.err_count = '0;
`endif

    assign bus.state     = state_q;
    assign bus.locked    = locked_q;
    assign bus.err       = err_q;
    assign bus.sync_lost = sync_lost_q;

endmodule

// File: tb/tb_galois_lfsr_checker.sv
// Self-checking bench for galois_lfsr_checker: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_galois_lfsr_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    galois_lfsr_checker_if bus();

    galois_lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef LFSR_CHK_ERR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sequence step as shift-right with a tap mask applied when bit 1 leaves.
    function automatic logic [15:0] model_next(input logic [15:0] q);
        return (q >> 1) ^ (q[1] ? 16'hC014 : 16'h0000);
    endfunction

    // Reference model: 0=HUNT 1=VERIFY 2=LOCKED
    int          m_state;
    int          m_match;
    int          m_miss;
    int          m_count;
    logic [15:0] m_exp;
    bit          m_err;
    bit          m_sl;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0; m_match = 0; m_miss = 0; m_count = 0;
            m_exp = 16'h0000; m_err = 0; m_sl = 0;
        end else begin
            m_err = 0;
            m_sl  = 0;
            if (bus.in_valid) begin
                if (m_state == 0) begin
                    if (bus.in_data != 16'h0000) begin
                        m_exp = model_next(bus.in_data);
                        m_match = 0;
                        m_state = 1;
                    end
                end else if (m_state == 1) begin
                    if (bus.in_data == m_exp) begin
                        m_exp = model_next(m_exp);
                        m_match++;
                        if (m_match >= 4) begin
                            m_state = 2;
                            m_miss = 0;
                        end
                    end else begin
                        m_state = 0;
                    end
                end else begin
                    if (bus.in_data == m_exp) begin
                        m_miss = 0;
                    end else begin
                        m_err = 1;
                        m_miss++;
                        if (CNT_EN && m_count < 65535) m_count++;
                        if (m_miss >= 3) begin
                            m_state = 0;
                            m_sl = 1;
                            m_miss = 0;
                        end
                    end
                    m_exp = model_next(m_exp);
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("state",     int'(bus.state),     m_state);
        check("locked",    int'(bus.locked),    int'(m_state == 2));
        check("err",       int'(bus.err),       int'(m_err));
        check("sync_lost", int'(bus.sync_lost), int'(m_sl));
        check("err_count", int'(bus.err_count), m_count);
    end

    task automatic send(input logic [15:0] w);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic lock_seq();
        send(16'h0400); send(16'h0200); send(16'h0100); send(16'h0080); send(16'h0040);
    endtask

    logic [15:0] seq_a [6] = '{16'h0020, 16'h0010, 16'h0008, 16'h0004, 16'h0002, 16'hC015};

    initial begin
        bit          v;
        int          r;
        int          rate;
        logic [15:0] d;

        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_state",  int'(bus.state),     0);
        check("rst_locked", int'(bus.locked),    0);
        check("rst_count",  int'(bus.err_count), 0);
        rst = 1'b0;

        // Zero word ignored; seed, gap, then continuation.
        send(16'h0000);
        check("zero_hunt", int'(bus.state), 0);
        send(16'h0400);
        idle(5);
        send(16'h0200);
        check("gap_verify", int'(bus.state), 1);
        send(16'h0100);
        send(16'h0080);
        check("pre_lock", int'(bus.locked), 0);
        send(16'h0040);
        check("gap_lock", int'(bus.locked), 1);

        // Clean continuation through a feedback step.
        foreach (seq_a[i]) send(seq_a[i]);
        check("seq_locked", int'(bus.locked),    1);
        check("seq_count",  int'(bus.err_count), 0);
        check("seq_state",  int'(bus.state),     2);

        // Single corrupted word while locked.
        do_reset();
        lock_seq();
        check("b2b_lock", int'(bus.locked), 1);
        send(16'h0021);
        check("single_err",    int'(bus.err),    1);
        check("single_locked", int'(bus.locked), 1);
        send(16'h0010);
        check("single_clear", int'(bus.err),       0);
        check("single_count", int'(bus.err_count), CNT_EN ? 1 : 0);

        // Three consecutive corrupted words drop lock.
        do_reset();
        lock_seq();
        send(16'h0021);
        send(16'h0011);
        check("loss_hold", int'(bus.locked), 1);
        send(16'h0009);
        check("loss_err",    int'(bus.err),       1);
        check("loss_sl",     int'(bus.sync_lost), 1);
        check("loss_state",  int'(bus.state),     0);
        check("loss_locked", int'(bus.locked),    0);
        check("loss_count",  int'(bus.err_count), CNT_EN ? 3 : 0);
        idle(1);
        check("loss_sl_drop", int'(bus.sync_lost), 0);

        // Asynchronous reset in VERIFY, observed before the next edge.
        send(16'h0400);
        send(16'h0200);
        check("mid_verify", int'(bus.state), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_state",  int'(bus.state),     0);
        check("async_locked", int'(bus.locked),    0);
        check("async_err",    int'(bus.err),       0);
        check("async_sl",     int'(bus.sync_lost), 0);
        check("async_count",  int'(bus.err_count), 0);
        @(negedge clk);
        rst = 1'b0;
        send(16'h1234);
        check("reseed", int'(bus.state), 1);
        send(16'h091A);
        check("reseed_next", int'(bus.state), 1);

        // Randomized traffic; corruption rate alternates to reach both lock and loss.
        rate = 2;
        for (int i = 0; i < 4000; i++) begin
            if ((i % 200) == 0) rate = ($urandom_range(0, 1) == 0) ? 2 : 40;
            if ($urandom_range(0, 299) == 0) begin
                bus.in_valid = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                v = ($urandom_range(0, 3) != 0);
                r = $urandom_range(0, 99);
                if (m_state == 0) begin
                    d = (r < 5) ? 16'h0000 : 16'($urandom());
                end else begin
                    d = m_exp;
                    if (r < rate) d = d ^ (16'h0001 << $urandom_range(0, 15));
                end
                bus.in_valid = v;
                bus.in_data  = d;
                @(negedge clk);
            end
        end

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/galois_lfsr_checker.md
GALOIS_LFSR_CHECKER -- requirements
Module: galois_lfsr_checker

Interface
REQ-001 Parameter: LOCK_CNT, default 4, consecutive matches needed in VERIFY to declare lock (range 1-15).
REQ-002 Parameter: LOSS_CNT, default 3, consecutive mismatches in LOCKED that drop lock (range 1-15).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  qualifies in_data for one cycle; words are consumed only when high.
REQ-006 in_data  input  16  received LFSR word, one per valid cycle.
REQ-007 locked  output  1  high while in LOCKED state.
REQ-008 err  output  1  one-cycle pulse: a LOCKED-state word mismatched.
REQ-009 sync_lost  output  1  one-cycle pulse on the LOCKED->HUNT transition.
REQ-010 err_count  output  16  saturating count of mismatches seen in LOCKED.
REQ-011 state  output  2  current FSM state encoding: HUNT=0, VERIFY=1, LOCKED=2.

Function
REQ-012 next(Q) is defined as: Q'[15]=Q[1]; Q'[14]=Q[15]^Q[1]; Q'[13:5]=Q[14:6]; Q'[4]=Q[5]^Q[1]; Q'[3]=Q[4]; Q'[2]=Q[3]^Q[1]; Q'[1]=Q[2]; Q'[0]=Q[1].
REQ-013 An internal 16-bit expected register holds the next predicted word.
REQ-014 HUNT: on a valid nonzero word W, expected<=next(W), match counter<=0, go to VERIFY; a valid word of 0x0000 is ignored and the FSM stays in HUNT.
REQ-015 VERIFY: on a valid word equal to expected, expected<=next(expected) and match counter increments; when the counter reaches LOCK_CNT, go to LOCKED.
REQ-016 VERIFY: on a valid word not equal to expected, go to HUNT; err is not pulsed and err_count is unchanged.
REQ-017 LOCKED: every valid word is compared with expected; expected<=next(expected) regardless of the compare result (flywheel).
REQ-018 LOCKED, match: the consecutive-miss counter clears.
REQ-019 LOCKED, mismatch: err pulses, err_count increments, and the miss counter increments.
REQ-020 LOCKED: when the miss counter reaches LOSS_CNT, go to HUNT and pulse sync_lost in the same cycle as the final err.
REQ-021 err, sync_lost, locked and state are registered; each appears exactly one clock after the rising edge that samples the causing valid word.
REQ-022 Cycles with in_valid low change no state, counters or outputs, except that pulse outputs return low.
REQ-023 err_count saturates at 0xFFFF and does not wrap; it is not cleared on loss of lock.
REQ-024 Comparison is on the full 16-bit word; any single-bit difference is a mismatch.

Reset
REQ-025 While rst is high: state=HUNT, expected=0x0000, match and miss counters=0, locked=0, err=0, sync_lost=0, err_count=0.
REQ-026 Reset asserted mid-sequence in any state returns to HUNT immediately; the first valid word after deassertion is treated as a HUNT seed.

Configuration
REQ-027 Macro LFSR_CHK_ERR_COUNT_EN: when defined, err_count is implemented as specified in REQ-010, REQ-019 and REQ-023.
REQ-028 When LFSR_CHK_ERR_COUNT_EN is undefined, err_count is tied to 0x0000 and no counter flops are synthesized; all other behaviour is identical.

Verification
REQ-029 Lock: valid words 0x0400,0x0200,0x0100,0x0080,0x0040 back to back -> locked=1 one cycle after 0x0040 is sampled; err never pulses.
REQ-030 Sequence check: continue after lock with 0x0020,0x0010,0x0008,0x0004,0x0002,0xC015 -> no err pulses; err_count=0.
REQ-031 Single error: while locked, send 0x0021 instead of 0x0020, then the correct continuation 0x0010 -> one err pulse, err_count=1, locked stays 1.
REQ-032 Loss: while locked with LOSS_CNT=3, send three consecutive corrupted words -> three err pulses, sync_lost pulses with the third, state=HUNT, locked=0, err_count=3 (macro defined) or 0 (undefined).
REQ-033 Zero and gaps: in HUNT, send 0x0000 -> stays HUNT; then 0x0400, idle 5 cycles, then 0x0200 -> state=VERIFY with match counter 1.
REQ-034 Reset mid-VERIFY: assert rst asynchronously between clock edges -> all outputs 0 before the next edge, state=HUNT.
